scalar_operand_fetch: RTL and testbench
=======================================

Name: scalar_operand_fetch

Overview:
- Operand-fetch stage between decode and execute; consumes the 1-cycle-latency scalar register file read data.
- Resolves every read/write hazard so execute always receives architecturally current operands:
  - the register file returns X when a register is read and written in the same cycle;
  - writebacks that land after the read are newer than the value read.
- Substitutes the PC for reads of register 31.
- Holds operands through execute stalls while continuing to snoop writeback.

Parameters:
- REG_IDX_WIDTH, 7, register index width: {strand id, 5-bit register number}; 4 strands x 32 registers.
- PC_REG, 31, register number (low 5 index bits) that reads as the instruction PC.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- ds_instruction_valid  in  1  decode presents an instruction this cycle.
- ds_scalar_sel1  in  REG_IDX_WIDTH  operand 1 index; the same signal drives the register file read port 1.
- ds_scalar_sel2  in  REG_IDX_WIDTH  operand 2 index; the same signal drives the register file read port 2.
- ds_pc  in  32  PC of the decode instruction.
- rf_scalar_value1  in  32  register file read data 1 (registered, 1 cycle after sel).
- rf_scalar_value2  in  32  register file read data 2.
- wb_enable_scalar_writeback  in  1  a writeback commits at this clock edge.
- wb_writeback_reg  in  REG_IDX_WIDTH  writeback index.
- wb_writeback_value  in  32  writeback data.
- ex_stall  in  1  execute cannot accept a new instruction.
- rollback  in  1  flush all in-flight instructions.
- of_stall  out  1  to decode: hold ds_* stable; equals ex_stall (combinational).
- of_instruction_valid  out  1  execute-stage instruction valid.
- of_operand1  out  32  resolved operand 1.
- of_operand2  out  32  resolved operand 2.
- of_pc  out  32  PC of the execute-stage instruction.

Behaviour:
- Pipeline:
  - s1 holds the instruction whose register file read is in flight.
  - "of" is the output register.
  - Latency: ds accepted at edge E; outputs valid after edge E+1, with no stall.
- s1 load (edge, ex_stall=0):
  - s1_valid<=ds_instruction_valid; s1_sel1/2<=ds_sel1/2; s1_pc<=ds_pc; s1_fresh<=1.
  - colN <= wb_enable && wb_reg==ds_selN.
  - capN <= wb_value.
- Resolved operand N, combinational in s1, in priority order:
  1. s1_selN[4:0]==PC_REG -> s1_pc.
  2. wb_enable && wb_reg==s1_selN -> wb_value (newest write wins).
  3. s1_fresh && colN -> capN.
  4. s1_fresh -> rf_scalar_valueN.
  5. Otherwise -> heldN.
- Every edge: heldN <= resolvedN.
- ex_stall=1:
  - s1 keeps valid/sel/pc; s1_fresh<=0.
  - "of" registers hold, except: if wb_enable && wb_reg==of_selN && of_selN[4:0]!=PC_REG, then of_operandN<=wb_value.
- ex_stall=0:
  - of_valid<=s1_valid; of_operandN<=resolvedN; of_pc<=s1_pc; of_selN<=s1_selN.
- Multi-cycle stall: after the first stall cycle, the register file output belongs to the next instruction and is ignored (s1_fresh=0). The held value plus snooping keeps operands current.
- rollback:
  - Next edge: s1_valid<=0 and of_valid<=0, regardless of ex_stall.
  - Other state is don't-care.
  - rollback has priority over stall.
- Operand hazards: sel1==sel2 with a collision resolves both operands identically. A write to another strand's index never forwards (full index compare).
- Reset, next edge:
  - of_instruction_valid=0, of_operand1/2=0, of_pc=0.
  - s1_valid=0, s1_fresh=0, col=0, held=0.
- Invalid instructions still propagate their operand values; only the valid bit matters.
- No X may ever reach of_operand* while of_instruction_valid=1.

Test Plan:
- Plain read: preload r5=0x1234. Issue sel1=5, sel2=6 (r6=0x55) at edge 0 -> after edge 1: valid=1, op1=0x1234, op2=0x55.
- Same-cycle collision: issue sel1=3 while wb writes r3=0xAAAA at the same edge -> op1=0xAAAA; never X.
- Post-read writeback: issue sel1=7 (r7=1), then wb r7=2 on the next edge -> op1=2.
- Stall snoop: issue sel1=9; hold ex_stall=1 for 3 cycles. During the stall, wb r9=0xBEEF (s1) and wb r9=0xCAFE later -> op1=0xCAFE when the stall releases. Separately, a write to of_sel while stalled updates of_operand.
- PC and strand isolation: sel1={strand1,31}, ds_pc=0x400 -> op1=0x400. Wb to {strand2,4} while reading {strand1,4} -> no forward.
- Rollback/reset: rollback while ex_stall=1 with both stages valid -> next cycle valid=0. Reset mid-stream -> all outputs 0, then normal operation resumes.

Source files
------------

// File: rtl/scalar_operand_fetch.sv
// Operand-fetch stage: resolves register-file read/write hazards, substitutes the PC
// for the PC register, and keeps operands current across execute stalls.
module scalar_operand_fetch #(
    parameter int REG_IDX_WIDTH = 7,
    parameter int PC_REG        = 31
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ds_instruction_valid,
    input  logic [REG_IDX_WIDTH-1:0] ds_scalar_sel1,
    input  logic [REG_IDX_WIDTH-1:0] ds_scalar_sel2,
    input  logic [31:0]              ds_pc,
    input  logic [31:0]              rf_scalar_value1,
    input  logic [31:0]              rf_scalar_value2,
    input  logic                     wb_enable_scalar_writeback,
    input  logic [REG_IDX_WIDTH-1:0] wb_writeback_reg,
    input  logic [31:0]              wb_writeback_value,
    input  logic                     ex_stall,
    input  logic                     rollback,
    output logic                     of_stall,
    output logic                     of_instruction_valid,
    output logic [31:0]              of_operand1,
    output logic [31:0]              of_operand2,
    output logic [31:0]              of_pc
);
    localparam logic [4:0] PC_NUM = 5'(PC_REG);

    logic                     s1_valid_q, s1_valid_d;
    logic [REG_IDX_WIDTH-1:0] s1_sel1_q, s1_sel1_d;
    logic [REG_IDX_WIDTH-1:0] s1_sel2_q, s1_sel2_d;
    logic [31:0]              s1_pc_q, s1_pc_d;
    logic                     s1_fresh_q, s1_fresh_d;
    logic                     col1_q, col1_d;
    logic                     col2_q, col2_d;
    logic [31:0]              cap1_q, cap1_d;
    logic [31:0]              cap2_q, cap2_d;
    logic [31:0]              held1_q, held1_d;
    logic [31:0]              held2_q, held2_d;
    logic                     of_valid_q, of_valid_d;
    logic [31:0]              of_operand1_q, of_operand1_d;
    logic [31:0]              of_operand2_q, of_operand2_d;
    logic [31:0]              of_pc_q, of_pc_d;
    logic [REG_IDX_WIDTH-1:0] of_sel1_q, of_sel1_d;
    logic [REG_IDX_WIDTH-1:0] of_sel2_q, of_sel2_d;

    logic [31:0] resolved1;
    logic [31:0] resolved2;

    // Newest source wins: PC, then this cycle's writeback, then the value written
    // on the read edge, then the RF read itself, else the value held from last edge.
    function automatic logic [31:0] resolve(
        input logic [REG_IDX_WIDTH-1:0] sel,
        input logic                     col,
        input logic [31:0]              cap,
        input logic [31:0]              rf_value,
        input logic [31:0]              held
    );
        logic [31:0] res;
        res = held;
        if (sel[4:0] == PC_NUM)
            res = s1_pc_q;
        else if (wb_enable_scalar_writeback && wb_writeback_reg == sel)
            res = wb_writeback_value;
        else if (s1_fresh_q && col)
            res = cap;
        else if (s1_fresh_q)
            res = rf_value;
        return res;
    endfunction

    always_comb begin
        resolved1 = resolve(s1_sel1_q, col1_q, cap1_q, rf_scalar_value1, held1_q);
        resolved2 = resolve(s1_sel2_q, col2_q, cap2_q, rf_scalar_value2, held2_q);
    end

    always_comb begin
        s1_valid_d    = s1_valid_q;
        s1_sel1_d     = s1_sel1_q;
        s1_sel2_d     = s1_sel2_q;
        s1_pc_d       = s1_pc_q;
        s1_fresh_d    = 1'b0;
        col1_d        = col1_q;
        col2_d        = col2_q;
        cap1_d        = cap1_q;
        cap2_d        = cap2_q;
        held1_d       = resolved1;
        held2_d       = resolved2;
        of_valid_d    = of_valid_q;
        of_operand1_d = of_operand1_q;
        of_operand2_d = of_operand2_q;
        of_pc_d       = of_pc_q;
        of_sel1_d     = of_sel1_q;
        of_sel2_d     = of_sel2_q;

        if (!ex_stall) begin
            s1_valid_d    = ds_instruction_valid;
            s1_sel1_d     = ds_scalar_sel1;
            s1_sel2_d     = ds_scalar_sel2;
            s1_pc_d       = ds_pc;
            s1_fresh_d    = 1'b1;
            col1_d        = wb_enable_scalar_writeback && (wb_writeback_reg == ds_scalar_sel1);
            col2_d        = wb_enable_scalar_writeback && (wb_writeback_reg == ds_scalar_sel2);
            cap1_d        = wb_writeback_value;
            cap2_d        = wb_writeback_value;
            of_valid_d    = s1_valid_q;
            of_operand1_d = resolved1;
            of_operand2_d = resolved2;
            of_pc_d       = s1_pc_q;
            of_sel1_d     = s1_sel1_q;
            of_sel2_d     = s1_sel2_q;
        end else begin
            // Stalled execute operands keep tracking writebacks; the PC register never does.
            if (wb_enable_scalar_writeback && wb_writeback_reg == of_sel1_q
                    && of_sel1_q[4:0] != PC_NUM)
                of_operand1_d = wb_writeback_value;
            if (wb_enable_scalar_writeback && wb_writeback_reg == of_sel2_q
                    && of_sel2_q[4:0] != PC_NUM)
                of_operand2_d = wb_writeback_value;
        end

        if (rollback) begin
            s1_valid_d = 1'b0;
            of_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q    <= 1'b0;
            s1_sel1_q     <= '0;
            s1_sel2_q     <= '0;
            s1_pc_q       <= '0;
            s1_fresh_q    <= 1'b0;
            col1_q        <= 1'b0;
            col2_q        <= 1'b0;
            cap1_q        <= '0;
            cap2_q        <= '0;
            held1_q       <= '0;
            held2_q       <= '0;
            of_valid_q    <= 1'b0;
            of_operand1_q <= '0;
            of_operand2_q <= '0;
            of_pc_q       <= '0;
            of_sel1_q     <= '0;
            of_sel2_q     <= '0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_sel1_q     <= s1_sel1_d;
            s1_sel2_q     <= s1_sel2_d;
            s1_pc_q       <= s1_pc_d;
            s1_fresh_q    <= s1_fresh_d;
            col1_q        <= col1_d;
            col2_q        <= col2_d;
            cap1_q        <= cap1_d;
            cap2_q        <= cap2_d;
            held1_q       <= held1_d;
            held2_q       <= held2_d;
            of_valid_q    <= of_valid_d;
            of_operand1_q <= of_operand1_d;
            of_operand2_q <= of_operand2_d;
            of_pc_q       <= of_pc_d;
            of_sel1_q     <= of_sel1_d;
            of_sel2_q     <= of_sel2_d;
        end
    end

    assign of_stall             = ex_stall;
    assign of_instruction_valid = of_valid_q;
    assign of_operand1          = of_operand1_q;
    assign of_operand2          = of_operand2_q;
    assign of_pc                = of_pc_q;

endmodule

// File: tb/tb_scalar_operand_fetch.sv
// Bench for scalar_operand_fetch: register-file model, architectural scoreboard,
// directed hazard scenarios followed by randomized traffic.
module tb_scalar_operand_fetch;
    logic        clk = 1'b0;
    logic        reset;
    logic        ds_instruction_valid;
    logic [6:0]  ds_scalar_sel1;
    logic [6:0]  ds_scalar_sel2;
    logic [31:0] ds_pc;
    logic [31:0] rf_scalar_value1;
    logic [31:0] rf_scalar_value2;
    logic        wb_enable_scalar_writeback;
    logic [6:0]  wb_writeback_reg;
    logic [31:0] wb_writeback_value;
    logic        ex_stall;
    logic        rollback;
    logic        of_stall;
    logic        of_instruction_valid;
    logic [31:0] of_operand1;
    logic [31:0] of_operand2;
    logic [31:0] of_pc;

    always #5 clk = ~clk;

    scalar_operand_fetch #(.REG_IDX_WIDTH(7), .PC_REG(31)) dut (
        .clk                        (clk),
        .reset                      (reset),
        .ds_instruction_valid       (ds_instruction_valid),
        .ds_scalar_sel1             (ds_scalar_sel1),
        .ds_scalar_sel2             (ds_scalar_sel2),
        .ds_pc                      (ds_pc),
        .rf_scalar_value1           (rf_scalar_value1),
        .rf_scalar_value2           (rf_scalar_value2),
        .wb_enable_scalar_writeback (wb_enable_scalar_writeback),
        .wb_writeback_reg           (wb_writeback_reg),
        .wb_writeback_value         (wb_writeback_value),
        .ex_stall                   (ex_stall),
        .rollback                   (rollback),
        .of_stall                   (of_stall),
        .of_instruction_valid       (of_instruction_valid),
        .of_operand1                (of_operand1),
        .of_operand2                (of_operand2),
        .of_pc                      (of_pc)
    );

    typedef struct packed {
        logic [6:0]  sel1;
        logic [6:0]  sel2;
        logic [31:0] pc;
    } instr_t;

    logic [31:0] regs [128];
    instr_t      sb_q [$];
    int          checks = 0;
    int          errors = 0;
    logic        mon_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] poison();
        return 32'hBAD0_0000 | 32'($urandom_range(0, 65535));
    endfunction

    // Architectural value an instruction must see when execute takes it.
    function automatic logic [31:0] arch_operand(input logic [6:0] sel, input logic [31:0] pc);
        return (sel[4:0] == 5'd31) ? pc : regs[sel];
    endfunction

    // Register file (1-cycle read, garbage on same-edge read/write) and scoreboard push.
    initial begin
        logic [31:0] r1, r2;
        forever begin
            @(posedge clk);
            r1 = (wb_enable_scalar_writeback && wb_writeback_reg == ds_scalar_sel1)
                 ? poison() : regs[ds_scalar_sel1];
            r2 = (wb_enable_scalar_writeback && wb_writeback_reg == ds_scalar_sel2)
                 ? poison() : regs[ds_scalar_sel2];
            if (reset || rollback)
                sb_q.delete();
            else if (ds_instruction_valid && !ex_stall)
                sb_q.push_back('{sel1: ds_scalar_sel1, sel2: ds_scalar_sel2, pc: ds_pc});
            if (wb_enable_scalar_writeback && !reset)
                regs[wb_writeback_reg] = wb_writeback_value;
            #1;
            rf_scalar_value1 = r1;
            rf_scalar_value2 = r2;
        end
    end

    // Monitor: whenever execute accepts a valid instruction, compare against the model.
    initial begin
        instr_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("of_stall", 32'(of_stall), 32'(ex_stall));
                if (of_instruction_valid === 1'b1 && ex_stall === 1'b0) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_valid", 32'(of_instruction_valid), 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        chk("operand1", of_operand1, arch_operand(e.sel1, e.pc));
                        chk("operand2", of_operand2, arch_operand(e.sel2, e.pc));
                        chk("pc", of_pc, e.pc);
                    end
                end
            end
        end
    end

    task automatic cyc(input logic v, input logic [6:0] a, input logic [6:0] b,
                       input logic [31:0] pc, input logic we, input logic [6:0] wr,
                       input logic [31:0] wv, input logic st, input logic rb);
        ds_instruction_valid       = v;
        ds_scalar_sel1             = a;
        ds_scalar_sel2             = b;
        ds_pc                      = pc;
        wb_enable_scalar_writeback = we;
        wb_writeback_reg           = wr;
        wb_writeback_value         = wv;
        ex_stall                   = st;
        rollback                   = rb;
        @(posedge clk);
        #2;
    endtask

    task automatic nop(input logic st);
        cyc(1'b0, 7'd0, 7'd0, 32'd0, 1'b0, 7'd0, 32'd0, st, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        nop(1'b0);
        reset = 1'b0;
        chk("rst_valid", 32'(of_instruction_valid), 32'd0);
        chk("rst_op1", of_operand1, 32'd0);
        chk("rst_op2", of_operand2, 32'd0);
        chk("rst_pc", of_pc, 32'd0);
        mon_en = 1'b1;
    endtask

    function automatic logic [6:0] rnd_idx();
        logic [4:0] n;
        case ($urandom_range(0, 4))
            0: n = 5'd1;
            1: n = 5'd2;
            2: n = 5'd31;
            3: n = 5'($urandom_range(0, 31));
            default: n = 5'd3;
        endcase
        return {2'($urandom_range(0, 1)), n};
    endfunction

    initial begin
        logic       last_stall;
        logic       v;
        logic [6:0] a, b;
        logic [31:0] pc;

        for (int i = 0; i < 128; i++) regs[i] = $urandom;
        regs[5]  = 32'h1234;
        regs[6]  = 32'h55;
        regs[7]  = 32'h1;
        regs[36] = 32'h3604;
        rf_scalar_value1 = '0;
        rf_scalar_value2 = '0;
        reset = 1'b1;
        nop(1'b0);
        do_reset();

        // Plain read, one-cycle latency
        cyc(1'b1, 7'd5, 7'd6, 32'h100, 1'b0, 7'd0, 32'd0, 1'b0, 1'b0);
        nop(1'b0);
        chk("plain_valid", 32'(of_instruction_valid), 32'd1);
        chk("plain_op1", of_operand1, 32'h1234);
        chk("plain_op2", of_operand2, 32'h55);

        // Same-edge read/write collision
        cyc(1'b1, 7'd3, 7'd6, 32'h104, 1'b1, 7'd3, 32'hAAAA, 1'b0, 1'b0);
        nop(1'b0);
        chk("collide_op1", of_operand1, 32'hAAAA);

        // Writeback landing after the read
        cyc(1'b1, 7'd7, 7'd7, 32'h108, 1'b0, 7'd0, 32'd0, 1'b0, 1'b0);
        cyc(1'b0, 7'd0, 7'd0, 32'd0, 1'b1, 7'd7, 32'h2, 1'b0, 1'b0);
        chk("postwb_op1", of_operand1, 32'h2);
        chk("postwb_op2", of_operand2, 32'h2);

        // Multi-cycle stall with the instruction in s1, then in the output stage
        cyc(1'b1, 7'd9, 7'd10, 32'h10C, 1'b0, 7'd0, 32'd0, 1'b0, 1'b0);
        cyc(1'b0, 7'd0, 7'd0, 32'd0, 1'b1, 7'd9, 32'hBEEF, 1'b1, 1'b0);
        nop(1'b1);
        cyc(1'b0, 7'd0, 7'd0, 32'd0, 1'b1, 7'd9, 32'hCAFE, 1'b1, 1'b0);
        nop(1'b0);
        chk("stall_s1_op1", of_operand1, 32'hCAFE);
        cyc(1'b0, 7'd0, 7'd0, 32'd0, 1'b1, 7'd9, 32'hF00D, 1'b1, 1'b0);
        chk("stall_of_op1", of_operand1, 32'hF00D);
        nop(1'b0);

        // PC substitution and strand isolation
        cyc(1'b1, {2'd1, 5'd31}, {2'd1, 5'd4}, 32'h400, 1'b1, {2'd2, 5'd4}, 32'h7777, 1'b0, 1'b0);
        cyc(1'b0, 7'd0, 7'd0, 32'd0, 1'b1, {2'd2, 5'd4}, 32'h8888, 1'b0, 1'b0);
        chk("pc_op1", of_operand1, 32'h400);
        chk("strand_op2", of_operand2, 32'h3604);

        // Rollback while stalled with both stages valid
        cyc(1'b1, 7'd1, 7'd2, 32'h500, 1'b0, 7'd0, 32'd0, 1'b0, 1'b0);
        cyc(1'b1, 7'd3, 7'd4, 32'h504, 1'b0, 7'd0, 32'd0, 1'b0, 1'b0);
        chk("pre_rb_valid", 32'(of_instruction_valid), 32'd1);
        cyc(1'b1, 7'd5, 7'd6, 32'h508, 1'b0, 7'd0, 32'd0, 1'b1, 1'b1);
        chk("rb_valid", 32'(of_instruction_valid), 32'd0);
        nop(1'b0);
        chk("rb_s1_valid", 32'(of_instruction_valid), 32'd0);

        // Reset mid-stream, then resume
        cyc(1'b1, 7'd1, 7'd2, 32'h600, 1'b0, 7'd0, 32'd0, 1'b0, 1'b0);
        cyc(1'b1, 7'd3, 7'd4, 32'h604, 1'b0, 7'd0, 32'd0, 1'b0, 1'b0);
        do_reset();
        cyc(1'b1, 7'd5, 7'd6, 32'h700, 1'b0, 7'd0, 32'd0, 1'b0, 1'b0);
        nop(1'b0);
        chk("resume_valid", 32'(of_instruction_valid), 32'd1);
        chk("resume_pc", of_pc, 32'h700);

        // Randomized traffic; decode holds its instruction while stalled
        last_stall = 1'b0;
        v = 1'b0; a = '0; b = '0; pc = '0;
        for (int i = 0; i < 4000; i++) begin
            if (!last_stall) begin
                v  = ($urandom_range(0, 3) != 0);
                a  = rnd_idx();
                b  = ($urandom_range(0, 3) == 0) ? a : rnd_idx();
                pc = $urandom;
            end
            reset = ($urandom_range(0, 299) == 0);
            last_stall = ($urandom_range(0, 9) < 3);
            cyc(v, a, b, pc, ($urandom_range(0, 1) == 1), rnd_idx(), $urandom,
                last_stall, ($urandom_range(0, 49) == 0));
        end
        reset = 1'b0;
        for (int i = 0; i < 5; i++) nop(1'b0);
        chk("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
